// File: rtl/seg7_pkg.sv
// seg7_pkg: scan state type, blank pattern and hex glyph table shared by the scan controller.
package seg7_pkg;

    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    typedef enum logic {GAP, SHOW} scan_state_t;

    // Active-low segments a..g for 0-9, A, b, C, d, E, F
    localparam logic [0:6] GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: producer-side load handshake and display controls for the scan controller.
interface seg7_scan_ctrl_if #(parameter int N_DIGITS = 4);

    logic [4*N_DIGITS-1:0] value_in;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   digit_en;
    logic                  lz_en;
    logic                  load;
    logic                  pending;
    logic                  frame_done;

    modport master (
        output value_in, dp_in, digit_en, lz_en, load,
        input  pending, frame_done
    );

    modport slave (
        input  value_in, dp_in, digit_en, lz_en, load,
        output pending, frame_done
    );

endinterface

// File: rtl/hex_seg_lut.sv
// hex_seg_lut: nibble to active-low 7-segment glyph, forced dark when blank.
module hex_seg_lut import seg7_pkg::*; (
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [0:6] seg
);

    assign seg = blank ? SEG_BLANK : GLYPH[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed N-digit common-anode scan with tear-free frame-boundary updates.
module seg7_scan_ctrl import seg7_pkg::*; #(
    parameter int N_DIGITS  = 4,
    parameter int PRESCALE  = 50000,
    parameter int GHOST_CYC = 2
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_ctrl_if.slave     bus,
    output logic [N_DIGITS-1:0] an,
    output logic [0:6]          seg,
    output logic                dp
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int VW = 4 * N_DIGITS;

    logic [PW-1:0]       pcnt;
    logic [IW-1:0]       idx;
    scan_state_t         state, state_n;
    logic [VW-1:0]       active, pend_val;
    logic [N_DIGITS-1:0] act_dp, pend_dp, an_n;
    logic                pend, slot_end, frame_end, zero_hi, blank;
    logic [0:6]          lut_seg;

    assign slot_end       = pcnt == PW'(PRESCALE - 1);
    assign frame_end      = slot_end && idx == IW'(N_DIGITS - 1);
    assign bus.pending    = pend;
    assign bus.frame_done = frame_end;

    always_ff @(posedge clk) begin
        if (rst)
            state <= GAP;
        else
            state <= state_n;
    end

    // Anode for the coming cycle is taken from the next state so it lines up with the FSM
    always_comb begin
        state_n = state;
        an_n    = '1;
        state_n = (state == GAP) ? ((pcnt == PW'(GHOST_CYC - 1)) ? SHOW : GAP)
                                 : (slot_end ? GAP : SHOW);
        an_n    = (state_n == SHOW) ? ~(N_DIGITS'(1) << idx) : '1;
    end

    // Digit i is leading-zero blank when it and every higher nibble are zero; digit 0 never is
    assign zero_hi = (active >> {idx, 2'b00}) == '0;
    assign blank   = !bus.digit_en[idx] || (bus.lz_en && idx != '0 && zero_hi);

    hex_seg_lut u_lut (
        .nibble (active[{idx, 2'b00} +: 4]),
        .blank  (blank),
        .seg    (lut_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt     <= '0;
            idx      <= '0;
            active   <= '0;
            act_dp   <= '0;
            pend_val <= '0;
            pend_dp  <= '0;
            pend     <= 1'b0;
            an       <= '1;
            seg      <= SEG_BLANK;
            dp       <= 1'b1;
        end else begin
            pcnt <= slot_end ? '0 : pcnt + 1'b1;
            if (slot_end)
                idx <= frame_end ? '0 : idx + 1'b1;
            if (frame_end && pend) begin
                active <= pend_val;
                act_dp <= pend_dp;
            end
            if (bus.load) begin
                pend_val <= bus.value_in;
                pend_dp  <= bus.dp_in;
            end
            pend <= bus.load || (pend && !frame_end);
            an   <= an_n;
            seg  <= lut_seg;
            dp   <= blank || !act_dp[idx];
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: scenario tasks checked against a time-indexed behavioural display model.
module tb_seg7_scan_ctrl;

    localparam int N = 4;
    localparam int P = 8;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] an;
    logic [0:6] seg;
    logic       dp;
    int         checks = 0;
    int         errors = 0;

    seg7_scan_ctrl_if #(.N_DIGITS(N)) bus ();

    seg7_scan_ctrl #(.N_DIGITS(N), .PRESCALE(P), .GHOST_CYC(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .an  (an),
        .seg (seg),
        .dp  (dp)
    );

    always #5 clk = ~clk;

    // Model: t = cycles since reset; displayed data swaps only at the end of the last slot
    int          t = 0;
    logic [15:0] m_act = '0, m_pv = '0;
    logic [3:0]  m_adp = '0, m_pdp = '0;
    logic        m_pend = 1'b0;
    string       segs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                               "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic fb_now();
        return (t % P == P - 1) && ((t / P) % N == N - 1);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            t      <= 0;
            m_act  <= '0;
            m_adp  <= '0;
            m_pv   <= '0;
            m_pdp  <= '0;
            m_pend <= 1'b0;
        end else begin
            t      <= t + 1;
            m_pend <= bus.load || (m_pend && !fb_now());
            if (fb_now() && m_pend) begin
                m_act <= m_pv;
                m_adp <= m_pdp;
            end
            if (bus.load) begin
                m_pv  <= bus.value_in;
                m_pdp <= bus.dp_in;
            end
        end
    end

    function automatic logic [0:6] glyph(logic [3:0] v);
        logic [0:6] r = '1;
        string s = segs[v];
        for (int k = 0; k < s.len(); k++) r[s[k] - 8'd97] = 1'b0;
        return r;
    endfunction

    function automatic logic [3:0] e_an();
        int d = (t / P) % N;
        return (t % P >= G) ? ~(4'b0001 << d) : 4'b1111;
    endfunction

    function automatic logic [7:0] e_sd();
        int d = (t / P) % N;
        logic bl = !bus.digit_en[d] || (bus.lz_en && d > 0 && (m_act >> (4 * d)) == 16'h0);
        return bl ? 8'hFF : {glyph(m_act[4 * d +: 4]), ~m_adp[d]};
    endfunction

    task automatic test_reset();
        bus.load = 1'b1;
        bus.value_in = 16'hFFFF;
        repeat (3) @(negedge clk);
        checks++;
        if ({an, seg, dp, bus.pending, bus.frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state an=%b seg=%b dp=%b pend=%b fd=%b want 1111 1111111 1 0 0", an, seg, dp, bus.pending, bus.frame_done);
        end
        rst = 1'b0;
        bus.load = 1'b0;
        @(negedge clk);
        checks++;
        if (an !== 4'hF) begin
            errors++;
            $display("FAIL reset_gap1 an=%b want 1111", an);
        end
        @(negedge clk);
        checks++;
        if (an !== 4'hE) begin
            errors++;
            $display("FAIL reset_first_show an=%b want 1110", an);
        end
    endtask

    task automatic test_scan();
        bus.value_in = 16'h1234;
        bus.load = 1'b1;
        for (int c = 0; c < 2 * N * P + 8; c++) begin
            @(negedge clk);
            bus.load = 1'b0;
            checks++;
            if ({bus.pending, bus.frame_done, an} !== {m_pend, fb_now(), e_an()} || (t % P >= G && {seg, dp} !== e_sd())) begin
                errors++;
                $display("FAIL scan t=%0d an=%b pend=%b fd=%b seg_dp=%b want an=%b pend=%b fd=%b seg_dp=%b",
                         t, an, bus.pending, bus.frame_done, {seg, dp}, e_an(), m_pend, fb_now(), e_sd());
            end
        end
    endtask

    task automatic test_tear();
        for (int c = 0; c < 3 * N * P; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.pending, bus.frame_done, an} !== {m_pend, fb_now(), e_an()} || (t % P >= G && {seg, dp} !== e_sd())) begin
                errors++;
                $display("FAIL tear t=%0d an=%b pend=%b fd=%b seg_dp=%b want an=%b pend=%b fd=%b seg_dp=%b",
                         t, an, bus.pending, bus.frame_done, {seg, dp}, e_an(), m_pend, fb_now(), e_sd());
            end
            bus.load = (c == 10) || (c == 40) || (c == 50);
            bus.value_in = (c == 10) ? 16'hABCD : (c == 40) ? 16'h1111 : 16'h2222;
        end
        bus.load = 1'b0;
    endtask

    task automatic test_lz();
        for (int c = 0; c < 6 * N * P; c++) begin
            if (c % (2 * N * P) == 0) begin
                bus.value_in = (c == 0) ? 16'h0050 : 16'h0000;
                bus.lz_en = (c < 4 * N * P);
                bus.load = 1'b1;
            end
            @(negedge clk);
            bus.load = 1'b0;
            checks++;
            if ({bus.pending, bus.frame_done, an} !== {m_pend, fb_now(), e_an()} || (t % P >= G && {seg, dp} !== e_sd())) begin
                errors++;
                $display("FAIL leading_zero t=%0d an=%b pend=%b fd=%b seg_dp=%b want an=%b pend=%b fd=%b seg_dp=%b",
                         t, an, bus.pending, bus.frame_done, {seg, dp}, e_an(), m_pend, fb_now(), e_sd());
            end
        end
    endtask

    task automatic test_masks();
        bus.digit_en = 4'b1010;
        bus.dp_in = 4'b0001;
        bus.value_in = 16'h8888;
        bus.load = 1'b1;
        for (int c = 0; c < 2 * N * P + 4; c++) begin
            @(negedge clk);
            bus.load = 1'b0;
            checks++;
            if (dp !== 1'b1 || {bus.pending, an} !== {m_pend, e_an()} || (t % P >= G && {seg, dp} !== e_sd())) begin
                errors++;
                $display("FAIL masks t=%0d an=%b pend=%b seg_dp=%b want an=%b pend=%b seg_dp=%b",
                         t, an, bus.pending, {seg, dp}, e_an(), m_pend, e_sd());
            end
        end
        bus.digit_en = 4'hF;
    endtask

    task automatic test_frame_load();
        int c = 0;
        bus.value_in = 16'h4321;
        bus.dp_in = 4'b0100;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        while (!fb_now() && c < 100) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (!fb_now()) begin
            errors++;
            $display("FAIL frame_load_wait no frame boundary within %0d cycles", c);
        end
        bus.value_in = 16'h9876;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        checks++;
        if (bus.pending !== 1'b1) begin
            errors++;
            $display("FAIL frame_load_pending pend=%b want 1", bus.pending);
        end
        for (int k = 0; k < 2 * N * P + 4; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.pending, bus.frame_done, an} !== {m_pend, fb_now(), e_an()} || (t % P >= G && {seg, dp} !== e_sd())) begin
                errors++;
                $display("FAIL frame_load t=%0d an=%b pend=%b fd=%b seg_dp=%b want an=%b pend=%b fd=%b seg_dp=%b",
                         t, an, bus.pending, bus.frame_done, {seg, dp}, e_an(), m_pend, fb_now(), e_sd());
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.pending, bus.frame_done, an} !== {m_pend, fb_now(), e_an()} || (t % P >= G && {seg, dp} !== e_sd())) begin
                errors++;
                $display("FAIL random t=%0d an=%b pend=%b fd=%b seg_dp=%b want an=%b pend=%b fd=%b seg_dp=%b",
                         t, an, bus.pending, bus.frame_done, {seg, dp}, e_an(), m_pend, fb_now(), e_sd());
            end
            bus.load = ($urandom_range(0, 12) == 0);
            bus.value_in = 16'($urandom) & (($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h00FF);
            bus.dp_in = 4'($urandom);
            if ($urandom_range(0, 30) == 0) bus.digit_en = 4'($urandom);
            if ($urandom_range(0, 30) == 0) bus.lz_en = 1'($urandom);
        end
        bus.load = 1'b0;
        bus.digit_en = 4'hF;
    endtask

    task automatic test_rst_mid();
        int c = 0;
        bus.value_in = 16'h5555;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        while (!((t / P) % N == 2 && t % P >= G) && c < 100) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (an !== 4'b1011) begin
            errors++;
            $display("FAIL rst_mid_show an=%b want 1011", an);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({an, bus.pending, bus.frame_done} !== {4'hF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_reset an=%b pend=%b fd=%b want 1111 0 0", an, bus.pending, bus.frame_done);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (an !== 4'hE) begin
            errors++;
            $display("FAIL rst_mid_idx0 an=%b want 1110", an);
        end
        for (int k = 0; k < N * P + 4; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.pending, an} !== {m_pend, e_an()} || (t % P >= G && {seg, dp} !== e_sd())) begin
                errors++;
                $display("FAIL rst_mid t=%0d an=%b pend=%b seg_dp=%b want an=%b pend=%b seg_dp=%b",
                         t, an, bus.pending, {seg, dp}, e_an(), m_pend, e_sd());
            end
        end
    endtask

    initial begin
        bus.value_in = '0;
        bus.dp_in = '0;
        bus.digit_en = 4'hF;
        bus.lz_en = 1'b0;
        bus.load = 1'b0;
        test_reset();
        test_scan();
        test_tear();
        test_lz();
        bus.lz_en = 1'b0;
        test_masks();
        test_frame_load();
        test_random();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
